// File: rtl/syn_stat_disp_if.sv
// Local-bus register port of the status/display controller.
// Single-cycle write/read strobes; read data returns one cycle later.
interface syn_stat_disp_if;
    logic        wr_en;
    logic        rd_en;
    logic [1:0]  addr;
    logic [31:0] wr_data;
    logic [31:0] rd_data;
    logic        rd_valid;

    modport master (
        output wr_en, rd_en, addr, wr_data,
        input  rd_data, rd_valid
    );

    modport slave (
        input  wr_en, rd_en, addr, wr_data,
        output rd_data, rd_valid
    );
endinterface

// File: rtl/syn_stat_disp.sv
// Board status/display controller: hex digits with blanking, LED modes,
// blink generator and synchronised, stretched event LEDs.
module syn_stat_disp #(
    parameter int P_NUM_DIGITS  = 4,
    parameter int P_NUM_LEDS    = 10,
    parameter int P_BLINK_DIV_W = 24,
    parameter int P_STRETCH_CYC = 50000
) (
    input  logic                      clk,
    input  logic                      rst,
    syn_stat_disp_if.slave            bus,
    input  logic [P_NUM_LEDS-1:0]     evt_i,
    output logic [7*P_NUM_DIGITS-1:0] seg_o,
    output logic [P_NUM_LEDS-1:0]     led_o
);

    localparam int ND = P_NUM_DIGITS;
    localparam int NL = P_NUM_LEDS;
    localparam int BW = P_BLINK_DIV_W;
    localparam int CW = $clog2(P_STRETCH_CYC + 1);
    localparam logic [CW-1:0] STRETCH = CW'(P_STRETCH_CYC);

    logic [4*ND-1:0] value_q, value_d;
    logic [ND-1:0]   en_q, en_d;
    logic            lzs_q, lzs_d;
    logic [2*NL-1:0] mode_q, mode_d;
    logic [31:0]     rd_data_q, rd_data_d;
    logic            rd_valid_q, rd_valid_d;
    logic [BW-1:0]   blink_q, blink_d;
    logic [NL-1:0]   sync1_q, sync1_d;
    logic [NL-1:0]   evt_s_q, evt_s_d;
    logic [CW-1:0]   cnt_q [NL];
    logic [CW-1:0]   cnt_d [NL];
    logic [7*ND-1:0] seg_q, seg_d;
    logic [NL-1:0]   led_q, led_d;
    logic [NL-1:0]   ev_on;
    logic [31:0]     rd_word;
    logic            nz;
    logic            unused_wr;

    assign unused_wr    = ^bus.wr_data;
    assign bus.rd_data  = rd_data_q;
    assign bus.rd_valid = rd_valid_q;
    assign seg_o        = seg_q;
    assign led_o        = led_q;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        logic [6:0] s;
        unique case (n)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            4'hF: s = 7'h0E;
        endcase
        return s;
    endfunction

    // Reads sample the registers before any same-edge write lands
    always_comb begin
        value_d = value_q;
        en_d    = en_q;
        lzs_d   = lzs_q;
        mode_d  = mode_q;
        if (bus.wr_en) begin
            case (bus.addr)
                2'd0: value_d = bus.wr_data[4*ND-1:0];
                2'd1: begin
                    en_d  = bus.wr_data[ND-1:0];
                    lzs_d = bus.wr_data[31];
                end
                2'd2: mode_d = bus.wr_data[2*NL-1:0];
                default: ;
            endcase
        end
        rd_word = '0;
        case (bus.addr)
            2'd0: rd_word[4*ND-1:0] = value_q;
            2'd1: begin
                rd_word[ND-1:0] = en_q;
                rd_word[31]     = lzs_q;
            end
            2'd2: rd_word[2*NL-1:0] = mode_q;
            default: ;
        endcase
        rd_valid_d = bus.rd_en;
        rd_data_d  = bus.rd_en ? rd_word : rd_data_q;
    end

    // nz tracks whether any nibble from the top down to digit i is nonzero
    always_comb begin
        seg_d = '1;
        nz    = 1'b0;
        for (int i = ND - 1; i >= 0; i--) begin
            nz = nz | (value_q[4*i +: 4] != 4'd0);
            if (en_q[i] && (nz || !lzs_q || i == 0))
                seg_d[7*i +: 7] = hex7(value_q[4*i +: 4]);
        end
    end

    always_comb begin
        blink_d = blink_q + BW'(1);
        sync1_d = evt_i;
        evt_s_d = sync1_q;
        for (int j = 0; j < NL; j++) begin
            cnt_d[j] = cnt_q[j];
            if (evt_s_q[j])
                cnt_d[j] = STRETCH;
            else if (cnt_q[j] != '0)
                cnt_d[j] = cnt_q[j] - CW'(1);
            ev_on[j] = evt_s_q[j] | (cnt_q[j] != '0);
        end
    end

    always_comb begin
        led_d = '0;
        for (int j = 0; j < NL; j++) begin
            case (mode_q[2*j +: 2])
                2'd0:    led_d[j] = 1'b0;
                2'd1:    led_d[j] = 1'b1;
                2'd2:    led_d[j] = blink_q[BW-1];
                default: led_d[j] = ev_on[j];
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value_q    <= '0;
            en_q       <= '0;
            lzs_q      <= 1'b0;
            mode_q     <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            blink_q    <= '0;
            sync1_q    <= '0;
            evt_s_q    <= '0;
            for (int j = 0; j < NL; j++) cnt_q[j] <= '0;
            seg_q      <= '1;
            led_q      <= '0;
        end else begin
            value_q    <= value_d;
            en_q       <= en_d;
            lzs_q      <= lzs_d;
            mode_q     <= mode_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            blink_q    <= blink_d;
            sync1_q    <= sync1_d;
            evt_s_q    <= evt_s_d;
            for (int j = 0; j < NL; j++) cnt_q[j] <= cnt_d[j];
            seg_q      <= seg_d;
            led_q      <= led_d;
        end
    end

endmodule

// File: tb/tb_syn_stat_disp.sv
// Bench for syn_stat_disp: directed steps plus random traffic checked
// against a history-based model of registers, digits and LEDs.
module tb_syn_stat_disp;

    localparam int ND = 4;
    localparam int NL = 10;
    localparam int BW = 4;
    localparam int SC = 5;
    localparam int HN = 4096;
    localparam logic [6:0] DEC [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [NL-1:0]   evt;
    logic [7*ND-1:0] seg;
    logic [NL-1:0]   led;

    always #5 clk = ~clk;

    syn_stat_disp_if bus ();

    syn_stat_disp #(
        .P_NUM_DIGITS (ND),
        .P_NUM_LEDS   (NL),
        .P_BLINK_DIV_W(BW),
        .P_STRETCH_CYC(SC)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus.slave),
        .evt_i(evt),
        .seg_o(seg),
        .led_o(led)
    );

    int checks = 0;
    int failures = 0;
    int t = 0;

    logic [15:0]   valh  [HN];
    logic [3:0]    enh   [HN];
    logic          lzsh  [HN];
    logic [19:0]   modeh [HN];
    logic [NL-1:0] evh   [HN];
    logic [15:0]   m_val;
    logic [3:0]    m_en;
    logic          m_lzs;
    logic [19:0]   m_mode;
    logic [31:0]   exp_rd;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [27:0] exp_seg(input logic [15:0] v,
                                            input logic [3:0] en,
                                            input logic lz);
        logic [27:0] r;
        r = '1;
        for (int i = 0; i < ND; i++) begin
            if (en[i] && !(lz && i != 0 && (v >> (4 * i)) == 16'd0))
                r[7*i +: 7] = DEC[v[4*i +: 4]];
        end
        return r;
    endfunction

    // Output after edge tt reflects state after edge tt-1; an event sampled
    // at edge k keeps the LED lit after edges k+2 .. k+2+SC
    function automatic logic [NL-1:0] exp_led(input int tt);
        logic [NL-1:0] r;
        logic [1:0] md;
        logic ev;
        int e;
        r = '0;
        if (tt < 1) return r;
        e = tt - 1;
        for (int j = 0; j < NL; j++) begin
            md = modeh[e][2*j +: 2];
            ev = 1'b0;
            for (int k = (e - 1 - SC < 1 ? 1 : e - 1 - SC); k <= e - 1; k++)
                if (evh[k][j]) ev = 1'b1;
            case (md)
                2'd0: r[j] = 1'b0;
                2'd1: r[j] = 1'b1;
                2'd2: r[j] = (e % (1 << BW)) >= (1 << (BW - 1));
                default: r[j] = ev;
            endcase
        end
        return r;
    endfunction

    function automatic logic [31:0] rd_model(input logic [1:0] a);
        case (a)
            2'd0: return {16'd0, m_val};
            2'd1: return {m_lzs, 27'd0, m_en};
            2'd2: return {12'd0, m_mode};
            default: return 32'd0;
        endcase
    endfunction

    task automatic cyc(input logic we, input logic re, input logic [1:0] a,
                       input logic [31:0] wd, input logic [NL-1:0] ev);
        @(negedge clk);
        bus.wr_en = we;
        bus.rd_en = re;
        bus.addr = a;
        bus.wr_data = wd;
        evt = ev;
        @(posedge clk);
        t++;
        evh[t] = ev;
        if (re) exp_rd = rd_model(a);
        if (we) begin
            case (a)
                2'd0: m_val = wd[15:0];
                2'd1: begin
                    m_en = wd[3:0];
                    m_lzs = wd[31];
                end
                2'd2: m_mode = wd[19:0];
                default: ;
            endcase
        end
        valh[t] = m_val;
        enh[t] = m_en;
        lzsh[t] = m_lzs;
        modeh[t] = m_mode;
        #1;
        chk("rd_valid", {31'd0, bus.rd_valid}, {31'd0, re});
        chk("rd_data", bus.rd_data, exp_rd);
        chk("seg", {4'd0, seg}, {4'd0, exp_seg(valh[t-1], enh[t-1], lzsh[t-1])});
        chk("led", {22'd0, led}, {22'd0, exp_led(t)});
    endtask

    // Assert reset off-edge; any pending read strobe is left driven
    task automatic hit_reset();
        rst = 1'b1;
        #1;
        chk("rst_seg", {4'd0, seg}, 32'h0FFFFFFF);
        chk("rst_led", {22'd0, led}, 32'd0);
        chk("rst_rd_valid", {31'd0, bus.rd_valid}, 32'd0);
        chk("rst_rd_data", bus.rd_data, 32'd0);
        m_val = '0;
        m_en = '0;
        m_lzs = 1'b0;
        m_mode = '0;
        exp_rd = '0;
        t = 0;
        valh[0] = '0;
        enh[0] = '0;
        lzsh[0] = 1'b0;
        modeh[0] = '0;
        evh[0] = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_hold_rd_valid", {31'd0, bus.rd_valid}, 32'd0);
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        bus.addr = '0;
        bus.wr_data = '0;
        evt = '0;
        rst = 1'b0;
    endtask

    initial begin
        int hi;
        int first;
        logic [NL-1:0] rev;
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        bus.addr = '0;
        bus.wr_data = '0;
        evt = '0;
        #2;
        hit_reset();

        // Reset-state reads, single-cycle rd_valid
        cyc(1'b0, 1'b1, 2'd0, 32'd0, '0);
        cyc(1'b0, 1'b1, 2'd1, 32'd0, '0);
        cyc(1'b0, 1'b1, 2'd2, 32'd0, '0);
        cyc(1'b0, 1'b0, 2'd0, 32'd0, '0);

        // Plain hex display
        cyc(1'b1, 1'b0, 2'd1, 32'h0000000F, '0);
        cyc(1'b1, 1'b0, 2'd0, 32'h000012AF, '0);
        cyc(1'b0, 1'b0, 2'd0, 32'd0, '0);
        chk("seg_12AF", {4'd0, seg}, {4'd0, 7'h79, 7'h24, 7'h08, 7'h0E});
        cyc(1'b0, 1'b1, 2'd0, 32'd0, '0);
        chk("rd_value", bus.rd_data, 32'h000012AF);

        // Leading-zero suppression
        cyc(1'b1, 1'b0, 2'd1, 32'h8000000F, '0);
        cyc(1'b1, 1'b0, 2'd0, 32'h00000030, '0);
        cyc(1'b0, 1'b0, 2'd0, 32'd0, '0);
        chk("seg_lzs_30", {4'd0, seg}, {4'd0, 7'h7F, 7'h7F, 7'h30, 7'h40});
        cyc(1'b1, 1'b0, 2'd0, 32'h00000000, '0);
        cyc(1'b0, 1'b0, 2'd0, 32'd0, '0);
        chk("seg_lzs_0", {4'd0, seg}, {4'd0, 7'h7F, 7'h7F, 7'h7F, 7'h40});

        // Same-edge write and read returns the old value
        cyc(1'b1, 1'b1, 2'd0, 32'h0000BEEF, '0);
        chk("rd_pre_write", bus.rd_data, 32'd0);

        // LED0 on, LED1 blink, LED2 event; reserved address
        cyc(1'b1, 1'b0, 2'd2, 32'h00000039, '0);
        cyc(1'b1, 1'b0, 2'd3, 32'hFFFFFFFF, '0);
        cyc(1'b0, 1'b1, 2'd3, 32'd0, '0);
        chk("rd_addr3", bus.rd_data, 32'd0);
        repeat (20) cyc(1'b0, 1'b0, 2'd0, 32'd0, '0);
        chk("led0_on", {31'd0, led[0]}, 32'd1);

        // Single event pulse: latency and stretch length
        cyc(1'b0, 1'b0, 2'd0, 32'd0, 10'b100);
        hi = 0;
        first = -1;
        for (int i = 1; i <= 12; i++) begin
            cyc(1'b0, 1'b0, 2'd0, 32'd0, '0);
            if (led[2]) begin
                hi++;
                if (first < 0) first = i;
            end
        end
        chk("evt_latency", first, 32'd2);
        chk("evt_stretch", hi, 32'd6);

        // Re-trigger inside the stretch: one contiguous on-period
        hi = 0;
        for (int i = 1; i <= 16; i++) begin
            cyc(1'b0, 1'b0, 2'd0, 32'd0, (i == 1 || i == 5) ? 10'b100 : 10'b0);
            if (led[2]) hi++;
        end
        chk("evt_retrigger", hi, 32'd10);

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            rev = NL'($urandom & $urandom & $urandom);
            cyc($urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
                2'($urandom_range(0, 3)), $urandom, rev);
        end

        // Reset during a stretch with a read response and a pending read
        cyc(1'b1, 1'b0, 2'd2, 32'h00000039, '0);
        cyc(1'b0, 1'b0, 2'd0, 32'd0, 10'b100);
        cyc(1'b0, 1'b0, 2'd0, 32'd0, '0);
        cyc(1'b0, 1'b1, 2'd2, 32'd0, '0);
        chk("pre_rst_led2", {31'd0, led[2]}, 32'd1);
        @(negedge clk);
        bus.rd_en = 1'b1;
        bus.addr = 2'd2;
        #2;
        hit_reset();
        cyc(1'b0, 1'b0, 2'd0, 32'd0, '0);
        cyc(1'b0, 1'b1, 2'd0, 32'd0, '0);
        cyc(1'b0, 1'b1, 2'd1, 32'd0, '0);
        cyc(1'b0, 1'b1, 2'd2, 32'd0, '0);
        chk("post_rst_mode", bus.rd_data, 32'd0);
        repeat (4) cyc(1'b0, 1'b0, 2'd0, 32'd0, '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
